// File: rtl/oram_ctrl_pkg.sv
// Shared types and constants for the Path ORAM access controller.
// Holds the FSM state encoding, DDR command codes and path-size helpers.
package oram_ctrl_pkg;

   typedef enum logic [2:0] {
      IDLE,
      RD_CMD,
      RD_WAIT,
      WB_WAIT,
      WR,
      DONE
   } state_t;

   localparam logic [2:0] DDR_CMD_READ  = 3'b001;
   localparam logic [2:0] DDR_CMD_WRITE = 3'b000;

   // Number of bursts covering one root-to-leaf path.
   function automatic int pathTotal(input int oramL, input int bktBeats);
      return (oramL + 1) * bktBeats;
   endfunction

   function automatic int cntWidth(input int total);
      return $clog2(total + 1);
   endfunction

endpackage

// File: rtl/path_access_ctrl_if.sv
// Frontend/stash handshake plus DRAM command/data port of the path access controller.
// The master modport is the controller's view; slave is the environment's view.
interface path_access_ctrl_if #(
   parameter int ORAML     = 10,
   parameter int DDRAWidth = 27,
   parameter int DDRCWidth = 3,
   parameter int DDRDWidth = 512
);
   logic [ORAML-1:0]     ReqLeaf;
   logic                 ReqValid;
   logic                 ReqReady;
   logic                 WritebackReady;
   logic [DDRDWidth-1:0] EvictData;
   logic                 EvictValid;
   logic                 EvictReady;
   logic                 PathReadDone;
   logic                 AccessDone;
   logic                 ProtocolError;
   logic [DDRAWidth-1:0] DRAMCommandAddress;
   logic [DDRCWidth-1:0] DRAMCommand;
   logic                 DRAMCommandValid;
   logic                 DRAMCommandReady;
   logic                 DRAMReadDataValid;
   logic [DDRDWidth-1:0] DRAMWriteData;
   logic                 DRAMWriteDataValid;
   logic                 DRAMWriteDataReady;

   modport master (
      input  ReqLeaf, ReqValid, WritebackReady, EvictData, EvictValid,
             DRAMCommandReady, DRAMReadDataValid, DRAMWriteDataReady,
      output ReqReady, EvictReady, PathReadDone, AccessDone, ProtocolError,
             DRAMCommandAddress, DRAMCommand, DRAMCommandValid,
             DRAMWriteData, DRAMWriteDataValid
   );

   modport slave (
      output ReqLeaf, ReqValid, WritebackReady, EvictData, EvictValid,
             DRAMCommandReady, DRAMReadDataValid, DRAMWriteDataReady,
      input  ReqReady, EvictReady, PathReadDone, AccessDone, ProtocolError,
             DRAMCommandAddress, DRAMCommand, DRAMCommandValid,
             DRAMWriteData, DRAMWriteDataValid
   );

endinterface

// File: rtl/path_addr_calc.sv
// Maps (leaf, level, beat) to a DRAM burst address using a flat heap layout of buckets.
// Kept separate so a subtree-packed layout can later replace it without touching the FSM.
module path_addr_calc #(
   parameter int ORAML      = 10,
   parameter int BKT_BEATS  = 4,
   parameter int DDRAWidth  = 27,
   parameter int ADDR_SHIFT = 3
) (
   input  logic [ORAML-1:0]     i_leaf,
   input  logic [31:0]          i_level,
   input  logic [31:0]          i_beat,
   output logic [DDRAWidth-1:0] o_addr
);

   logic [63:0] w_node;
   logic [63:0] w_burst;

   // Heap node index of the bucket on the leaf's path at this level; out-of-range levels map to 0.
   always_comb begin
      w_node = '0;
      if (i_level <= 32'(ORAML))
         w_node = ((64'd1 << i_level) - 64'd1) + (64'(i_leaf) >> (32'(ORAML) - i_level));
      w_burst = (w_node * 64'(BKT_BEATS)) + 64'(i_beat);
   end

   assign o_addr = DDRAWidth'(w_burst << ADDR_SHIFT);

endmodule

// File: rtl/path_access_ctrl.sv
// Sequences one Path ORAM access: read bursts for a whole path, wait for the stash,
// then write the same path back while forwarding stash eviction beats to DRAM.
module path_access_ctrl
   import oram_ctrl_pkg::*;
#(
   parameter int ORAML      = 10,
   parameter int BKT_BEATS  = 4,
   parameter int DDRAWidth  = 27,
   parameter int DDRCWidth  = 3,
   parameter int DDRDWidth  = 512,
   parameter int ADDR_SHIFT = 3
) (
   input logic              clk,
   input logic              rst_n,
   path_access_ctrl_if.master bus
);

   localparam int TOTAL = pathTotal(ORAML, BKT_BEATS);
   localparam int CW    = cntWidth(TOTAL);
   localparam logic [CW-1:0] TOT = CW'(TOTAL);

   state_t           r_state;
   logic [ORAML-1:0] r_leaf;
   logic [CW-1:0]    r_cmdcnt;
   logic [CW-1:0]    r_rdcnt;
   logic [CW-1:0]    r_wdat;
   logic             r_protErr;

   logic                 w_inRead;
   logic                 w_cmdValid;
   logic                 w_cmdAccept;
   logic                 w_wdatOpen;
   logic                 w_datAccept;
   logic                 w_rdBeat;
   logic [CW-1:0]        w_cmdcntNext;
   logic [CW-1:0]        w_rdcntNext;
   logic [CW-1:0]        w_wdatNext;
   logic                 w_lastRdCmd;
   logic                 w_readDone;
   logic [31:0]          w_level;
   logic [31:0]          w_beat;
   logic [DDRAWidth-1:0] w_calcAddr;

   // One command counter serves both phases; it is cleared on entry to the write phase.
   assign w_inRead     = (r_state == RD_CMD) || (r_state == RD_WAIT);
   assign w_cmdValid   = (r_state == RD_CMD) || ((r_state == WR) && (r_cmdcnt < TOT));
   assign w_cmdAccept  = w_cmdValid && bus.DRAMCommandReady;
   assign w_wdatOpen   = (r_state == WR) && (r_wdat < TOT);
   assign w_datAccept  = w_wdatOpen && bus.EvictValid && bus.DRAMWriteDataReady;
   assign w_rdBeat     = w_inRead && bus.DRAMReadDataValid && (r_rdcnt < TOT);
   assign w_cmdcntNext = r_cmdcnt + CW'(w_cmdAccept);
   assign w_rdcntNext  = r_rdcnt + CW'(w_rdBeat);
   assign w_wdatNext   = r_wdat + CW'(w_datAccept);
   assign w_lastRdCmd  = (r_state == RD_CMD) && (w_cmdcntNext == TOT);
   assign w_readDone   = ((r_state == RD_WAIT) || w_lastRdCmd) && (w_rdcntNext == TOT);

   assign w_level = 32'(r_cmdcnt) / 32'(BKT_BEATS);
   assign w_beat  = 32'(r_cmdcnt) % 32'(BKT_BEATS);

   path_addr_calc #(
      .ORAML      (ORAML),
      .BKT_BEATS  (BKT_BEATS),
      .DDRAWidth  (DDRAWidth),
      .ADDR_SHIFT (ADDR_SHIFT)
   ) u_addr (
      .i_leaf  (r_leaf),
      .i_level (w_level),
      .i_beat  (w_beat),
      .o_addr  (w_calcAddr)
   );

   // Access sequencer; read beats outside the read phases only raise the sticky error.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= IDLE;
         r_leaf    <= '0;
         r_cmdcnt  <= '0;
         r_rdcnt   <= '0;
         r_wdat    <= '0;
         r_protErr <= 1'b0;
      end else begin
         if (bus.DRAMReadDataValid && !w_inRead)
            r_protErr <= 1'b1;
         unique case (r_state)
            IDLE: begin
               if (bus.ReqValid) begin
                  r_leaf   <= bus.ReqLeaf;
                  r_cmdcnt <= '0;
                  r_rdcnt  <= '0;
                  r_wdat   <= '0;
                  r_state  <= RD_CMD;
               end
            end
            RD_CMD: begin
               r_cmdcnt <= w_cmdcntNext;
               r_rdcnt  <= w_rdcntNext;
               if (w_lastRdCmd)
                  r_state <= w_readDone ? WB_WAIT : RD_WAIT;
            end
            RD_WAIT: begin
               r_rdcnt <= w_rdcntNext;
               if (w_readDone)
                  r_state <= WB_WAIT;
            end
            WB_WAIT: begin
               if (bus.WritebackReady) begin
                  r_cmdcnt <= '0;
                  r_wdat   <= '0;
                  r_state  <= WR;
               end
            end
            WR: begin
               r_cmdcnt <= w_cmdcntNext;
               r_wdat   <= w_wdatNext;
               if ((w_cmdcntNext == TOT) && (w_wdatNext == TOT))
                  r_state <= DONE;
            end
            DONE:    r_state <= IDLE;
            default: r_state <= IDLE;
         endcase
      end
   end

   assign bus.ReqReady           = (r_state == IDLE);
   assign bus.DRAMCommandValid   = w_cmdValid;
   assign bus.DRAMCommand        = (r_state == WR) ? DDRCWidth'(DDR_CMD_WRITE) : DDRCWidth'(DDR_CMD_READ);
   assign bus.DRAMCommandAddress = w_cmdValid ? w_calcAddr : '0;
   assign bus.DRAMWriteData      = bus.EvictData;
   assign bus.DRAMWriteDataValid = w_wdatOpen && bus.EvictValid;
   assign bus.EvictReady         = w_wdatOpen && bus.DRAMWriteDataReady;
   assign bus.PathReadDone       = w_readDone;
   assign bus.AccessDone         = (r_state == DONE);
   assign bus.ProtocolError      = r_protErr;

endmodule

// File: tb/tb_path_access_ctrl.sv
// Self-checking bench for path_access_ctrl: a constant vector table for the nominal access,
// then randomized accesses checked against a queue-based model of the path access rules.
module tb_path_access_ctrl;
   import oram_ctrl_pkg::*;

   localparam int ORAML = 3;
   localparam int BKT   = 2;
   localparam int AW    = 27;
   localparam int CWID  = 3;
   localparam int DW    = 64;
   localparam int SHIFT = 3;
   localparam int TOTAL = (ORAML + 1) * BKT;

   typedef struct {
      logic          reqValid;
      logic          cmdReady;
      logic          rdValid;
      logic          wbReady;
      logic          evValid;
      logic          wrReady;
      logic          eReqReady;
      logic          eCmdValid;
      logic [2:0]    eCmd;
      logic [AW-1:0] eAddr;
      logic          ePrd;
      logic          eAd;
      logic          eEvReady;
      logic          eWrValid;
   } vec_t;

   logic clk;
   logic rst_n;
   int   nChecks;
   int   nFails;
   vec_t tab[$];

   path_access_ctrl_if #(
      .ORAML(ORAML), .DDRAWidth(AW), .DDRCWidth(CWID), .DDRDWidth(DW)
   ) bus ();

   path_access_ctrl #(
      .ORAML(ORAML), .BKT_BEATS(BKT), .DDRAWidth(AW), .DDRCWidth(CWID),
      .DDRDWidth(DW), .ADDR_SHIFT(SHIFT)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // Free-running clock, 10 ns period.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Hard stop in case some wait is never satisfied.
   initial begin
      #200us;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      nChecks++;
      if (actual !== expected) begin
         nFails++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
      end
   endtask

   task automatic reportTimeout(input string name);
      nChecks++;
      nFails++;
      $display("[TB] FAIL %s: cycle budget exhausted at %0t", name, $time);
   endtask

   // Address of the idx-th burst on the path to leaf, straight from the heap layout rule.
   function automatic logic [AW-1:0] refAddr(input int leaf, input int idx);
      int     lvl;
      int     beat;
      longint node;
      lvl  = idx / BKT;
      beat = idx % BKT;
      node = longint'((1 << lvl) - 1) + longint'(leaf >> (ORAML - lvl));
      return AW'((node * BKT + beat) << SHIFT);
   endfunction

   task automatic clearInputs();
      bus.ReqValid           = 1'b0;
      bus.ReqLeaf            = '0;
      bus.WritebackReady     = 1'b0;
      bus.EvictData          = '0;
      bus.EvictValid         = 1'b0;
      bus.DRAMCommandReady   = 1'b0;
      bus.DRAMReadDataValid  = 1'b0;
      bus.DRAMWriteDataReady = 1'b0;
   endtask

   task automatic applyReset();
      rst_n = 1'b0;
      clearInputs();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic applyStimulus(input vec_t v, input logic [ORAML-1:0] leaf, input logic [DW-1:0] data);
      bus.ReqValid           = v.reqValid;
      bus.ReqLeaf            = leaf;
      bus.DRAMCommandReady   = v.cmdReady;
      bus.DRAMReadDataValid  = v.rdValid;
      bus.WritebackReady     = v.wbReady;
      bus.EvictValid         = v.evValid;
      bus.DRAMWriteDataReady = v.wrReady;
      bus.EvictData          = data;
   endtask

   function automatic void addRow(input logic rq, input logic cr, input logic rv, input logic wb,
                                  input logic ev, input logic wr, input logic eRq, input logic eCv,
                                  input logic [2:0] eCmd, input logic [AW-1:0] eAddr, input logic ePrd,
                                  input logic eAd, input logic eEr, input logic eWv);
      vec_t v;
      v.reqValid = rq;  v.cmdReady = cr;  v.rdValid = rv;   v.wbReady = wb;
      v.evValid = ev;   v.wrReady = wr;   v.eReqReady = eRq; v.eCmdValid = eCv;
      v.eCmd = eCmd;    v.eAddr = eAddr;  v.ePrd = ePrd;     v.eAd = eAd;
      v.eEvReady = eEr; v.eWrValid = eWv;
      tab.push_back(v);
   endfunction

   // One full access driven with the chosen handshake patterns, checked cycle by cycle
   // against counts of commands issued and beats moved so far.
   // rdMode: 0 beats after all commands, 1 Ready toggling, 2 beat with every command, 3 random.
   // wrMode: 0 all ready, 1 all data before any write command, 2 random.
   task automatic runAccess(input logic [ORAML-1:0] leaf, input int rdMode, input int wbHold, input int wrMode);
      logic [AW-1:0] q[$];
      int            issued;
      int            beats;
      int            wcmd;
      int            wdat;
      int            cyc;
      bit            readSignalled;
      bit            cr;
      bit            rv;
      bit            ev;
      bit            wr;
      bit            expValid;
      logic [DW-1:0] data;
      issued = 0; beats = 0; wcmd = 0; wdat = 0; readSignalled = 0;
      for (int i = 0; i < TOTAL; i++) q.push_back(refAddr(int'(leaf), i));

      clearInputs();
      bus.ReqValid = 1'b1;
      bus.ReqLeaf  = leaf;
      #1 checkOutput("req ReqReady", 64'(bus.ReqReady), 64'd1);
      @(negedge clk);
      bus.ReqValid = 1'b0;

      cyc = 0;
      while (!readSignalled && cyc < 200) begin
         case (rdMode)
            0:       begin cr = 1'b1; rv = (issued == TOTAL); end
            1:       begin cr = (cyc % 2 == 0); rv = (issued == TOTAL); end
            2:       begin cr = 1'b1; rv = 1'b1; end
            default: begin cr = 1'($urandom_range(0, 1)); rv = (beats < issued) && ($urandom_range(0, 1) == 1); end
         endcase
         bus.DRAMCommandReady  = cr;
         bus.DRAMReadDataValid = rv;
         #1;
         expValid = (issued < TOTAL);
         checkOutput("rd CmdValid", 64'(bus.DRAMCommandValid), 64'(expValid));
         if (expValid) begin
            checkOutput("rd Command", 64'(bus.DRAMCommand), 64'(DDR_CMD_READ));
            checkOutput($sformatf("rd addr %0d", issued), 64'(bus.DRAMCommandAddress), 64'(q[issued]));
         end
         checkOutput("rd ReqReady", 64'(bus.ReqReady), 64'd0);
         if (expValid && cr) issued++;
         if (rv && beats < TOTAL) beats++;
         readSignalled = (issued == TOTAL) && (beats == TOTAL);
         checkOutput("rd PathReadDone", 64'(bus.PathReadDone), 64'(readSignalled));
         cyc++;
         @(negedge clk);
      end
      if (!readSignalled) reportTimeout("read phase");

      bus.DRAMReadDataValid  = 1'b0;
      bus.DRAMCommandReady   = 1'b1;
      bus.EvictValid         = 1'b1;
      bus.DRAMWriteDataReady = 1'b1;
      for (int k = 0; k <= wbHold; k++) begin
         bus.WritebackReady = (k == wbHold);
         #1;
         checkOutput("wb CmdValid", 64'(bus.DRAMCommandValid), 64'd0);
         checkOutput("wb EvictReady", 64'(bus.EvictReady), 64'd0);
         checkOutput("wb WrValid", 64'(bus.DRAMWriteDataValid), 64'd0);
         @(negedge clk);
      end
      bus.WritebackReady = 1'b0;

      cyc = 0;
      while (!(wcmd == TOTAL && wdat == TOTAL) && cyc < 200) begin
         case (wrMode)
            0:       begin cr = 1'b1; ev = 1'b1; wr = 1'b1; end
            1:       begin cr = (wdat == TOTAL); ev = 1'b1; wr = 1'b1; end
            default: begin
               cr = 1'($urandom_range(0, 1));
               ev = 1'($urandom_range(0, 1));
               wr = 1'($urandom_range(0, 1));
            end
         endcase
         data = {$urandom, $urandom};
         bus.DRAMCommandReady   = cr;
         bus.EvictValid         = ev;
         bus.DRAMWriteDataReady = wr;
         bus.EvictData          = data;
         #1;
         expValid = (wcmd < TOTAL);
         checkOutput("wr CmdValid", 64'(bus.DRAMCommandValid), 64'(expValid));
         if (expValid) begin
            checkOutput("wr Command", 64'(bus.DRAMCommand), 64'(DDR_CMD_WRITE));
            checkOutput($sformatf("wr addr %0d", wcmd), 64'(bus.DRAMCommandAddress), 64'(q[wcmd]));
         end
         checkOutput("wr WrValid", 64'(bus.DRAMWriteDataValid), 64'(ev && wdat < TOTAL));
         checkOutput("wr EvictReady", 64'(bus.EvictReady), 64'(wr && wdat < TOTAL));
         checkOutput("wr data", 64'(bus.DRAMWriteData), 64'(data));
         checkOutput("wr AccessDone", 64'(bus.AccessDone), 64'd0);
         if (expValid && cr) wcmd++;
         if (ev && wr && wdat < TOTAL) wdat++;
         cyc++;
         @(negedge clk);
      end
      if (!(wcmd == TOTAL && wdat == TOTAL)) reportTimeout("write phase");

      clearInputs();
      #1;
      checkOutput("done AccessDone", 64'(bus.AccessDone), 64'd1);
      checkOutput("done ReqReady", 64'(bus.ReqReady), 64'd0);
      @(negedge clk);
      #1;
      checkOutput("idle ReqReady", 64'(bus.ReqReady), 64'd1);
      checkOutput("idle AccessDone", 64'(bus.AccessDone), 64'd0);
      @(negedge clk);
   endtask

   initial begin
      logic [AW-1:0] leaf5Addr [8];
      logic [DW-1:0] data;
      nChecks = 0;
      nFails  = 0;
      leaf5Addr = '{27'd0, 27'd8, 27'd32, 27'd40, 27'd80, 27'd88, 27'd192, 27'd200};

      // Reset values.
      applyReset();
      #1;
      checkOutput("reset ReqReady", 64'(bus.ReqReady), 64'd1);
      checkOutput("reset CmdValid", 64'(bus.DRAMCommandValid), 64'd0);
      checkOutput("reset Command", 64'(bus.DRAMCommand), 64'(DDR_CMD_READ));
      checkOutput("reset Address", 64'(bus.DRAMCommandAddress), 64'd0);
      checkOutput("reset WrValid", 64'(bus.DRAMWriteDataValid), 64'd0);
      checkOutput("reset EvictReady", 64'(bus.EvictReady), 64'd0);
      checkOutput("reset PathReadDone", 64'(bus.PathReadDone), 64'd0);
      checkOutput("reset AccessDone", 64'(bus.AccessDone), 64'd0);
      checkOutput("reset ProtocolError", 64'(bus.ProtocolError), 64'd0);
      @(negedge clk);

      // Nominal access to leaf 3'b101 with every Ready held high.
      addRow(1, 0, 0, 0, 0, 0,  1, 0, 3'b001, '0, 0, 0, 0, 0);
      for (int i = 0; i < 8; i++) addRow(0, 1, 0, 0, 0, 0,  0, 1, 3'b001, leaf5Addr[i], 0, 0, 0, 0);
      for (int i = 0; i < 8; i++) addRow(0, 0, 1, 0, 0, 0,  0, 0, 3'b001, '0, (i == 7), 0, 0, 0);
      addRow(0, 0, 0, 1, 0, 0,  0, 0, 3'b001, '0, 0, 0, 0, 0);
      for (int i = 0; i < 8; i++) addRow(0, 1, 0, 0, 1, 1,  0, 1, 3'b000, leaf5Addr[i], 0, 0, 1, 1);
      addRow(0, 0, 0, 0, 0, 0,  0, 0, 3'b001, '0, 0, 1, 0, 0);
      addRow(0, 0, 0, 0, 0, 0,  1, 0, 3'b001, '0, 0, 0, 0, 0);

      for (int i = 0; i < tab.size(); i++) begin
         data = {$urandom, $urandom};
         applyStimulus(tab[i], 3'b101, data);
         #1;
         checkOutput($sformatf("tab%0d ReqReady", i), 64'(bus.ReqReady), 64'(tab[i].eReqReady));
         checkOutput($sformatf("tab%0d CmdValid", i), 64'(bus.DRAMCommandValid), 64'(tab[i].eCmdValid));
         if (tab[i].eCmdValid) begin
            checkOutput($sformatf("tab%0d Command", i), 64'(bus.DRAMCommand), 64'(tab[i].eCmd));
            checkOutput($sformatf("tab%0d Address", i), 64'(bus.DRAMCommandAddress), 64'(tab[i].eAddr));
         end
         checkOutput($sformatf("tab%0d PathReadDone", i), 64'(bus.PathReadDone), 64'(tab[i].ePrd));
         checkOutput($sformatf("tab%0d AccessDone", i), 64'(bus.AccessDone), 64'(tab[i].eAd));
         checkOutput($sformatf("tab%0d EvictReady", i), 64'(bus.EvictReady), 64'(tab[i].eEvReady));
         checkOutput($sformatf("tab%0d WrValid", i), 64'(bus.DRAMWriteDataValid), 64'(tab[i].eWrValid));
         if (tab[i].evValid)
            checkOutput($sformatf("tab%0d WrData", i), 64'(bus.DRAMWriteData), 64'(data));
         @(negedge clk);
      end
      clearInputs();

      // Multi-cycle corner cases, then randomized accesses.
      runAccess(3'b101, 1, 0, 0);
      runAccess(3'($urandom_range(0, 7)), 2, 0, 0);
      runAccess(3'($urandom_range(0, 7)), 0, 20, 0);
      runAccess(3'($urandom_range(0, 7)), 0, 0, 1);
      for (int n = 0; n < 8; n++)
         runAccess(3'($urandom_range(0, 7)), 3, int'($urandom_range(0, 3)), 2);
      #1 checkOutput("no ProtocolError", 64'(bus.ProtocolError), 64'd0);
      @(negedge clk);

      // Reset in the middle of the read command phase.
      clearInputs();
      bus.ReqValid = 1'b1;
      bus.ReqLeaf  = 3'b110;
      @(negedge clk);
      bus.ReqValid         = 1'b0;
      bus.DRAMCommandReady = 1'b1;
      repeat (3) @(negedge clk);
      #1 checkOutput("midrst busy CmdValid", 64'(bus.DRAMCommandValid), 64'd1);
      #1 rst_n = 1'b0;
      #1;
      checkOutput("midrst ReqReady", 64'(bus.ReqReady), 64'd1);
      checkOutput("midrst CmdValid", 64'(bus.DRAMCommandValid), 64'd0);
      checkOutput("midrst Address", 64'(bus.DRAMCommandAddress), 64'd0);
      checkOutput("midrst Command", 64'(bus.DRAMCommand), 64'(DDR_CMD_READ));
      @(negedge clk);
      rst_n = 1'b1;
      clearInputs();
      for (int k = 0; k < 4; k++) begin
         #1;
         checkOutput("postrst ReqReady", 64'(bus.ReqReady), 64'd1);
         checkOutput("postrst AccessDone", 64'(bus.AccessDone), 64'd0);
         checkOutput("postrst ProtocolError", 64'(bus.ProtocolError), 64'd0);
         @(negedge clk);
      end
      bus.DRAMReadDataValid = 1'b1;
      @(negedge clk);
      bus.DRAMReadDataValid = 1'b0;
      #1 checkOutput("stray beat ProtocolError", 64'(bus.ProtocolError), 64'd1);
      @(negedge clk);
      runAccess(3'b011, 0, 0, 0);
      #1 checkOutput("sticky ProtocolError", 64'(bus.ProtocolError), 64'd1);
      @(negedge clk);
      applyReset();
      #1 checkOutput("cleared ProtocolError", 64'(bus.ProtocolError), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end

endmodule
